chip8_rom_loader: RTL and testbench
===================================

CHIP8_ROM_LOADER -- requirements
Module: chip8_rom_loader

Interface
REQ-001 SHALL have parameter PROGRAM_BASE, default 12'h200: RAM address of the first program byte.
REQ-002 SHALL have parameter FONT_BASE, default 12'h000: RAM address of the first font byte.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the source presents a program byte.
REQ-006 SHALL have port in_data, input, 8 bits: the program byte.
REQ-007 SHALL have port in_last, input, 1 bit: marks the final program byte; qualified by in_valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 SHALL have port reload, input, 1 bit: a single-cycle pulse that requests a new program load.
REQ-010 SHALL have port we, output, 1 bit: RAM write enable.
REQ-011 SHALL have port write_address, output, 12 bits: RAM write address.
REQ-012 SHALL have port d, output, 8 bits: RAM write data.
REQ-013 SHALL have port cpu_reset, output, 1 bit: holds chip8_cpu in reset while high.
REQ-014 SHALL have port done, output, 1 bit: high while the loaded program is running.
REQ-015 SHALL have port bytes_loaded, output, 12 bits: count of program bytes written in the last or current load.

Function
REQ-016 SHALL implement the FSM states FONT, LOAD, FLUSH and RUN; we, write_address, d, cpu_reset and done SHALL all be registered.
REQ-017 FONT: SHALL write the standard 80-byte CHIP-8 hex font (digits 0-F, 5 bytes each) to addresses FONT_BASE through FONT_BASE+79, one byte per cycle, with we high for 80 consecutive cycles.
REQ-018 After the font byte at FONT_BASE+79 is issued, the FSM SHALL go to LOAD on the next edge.
REQ-019 in_ready SHALL be 1 only in LOAD; it SHALL be combinational from state only, never from in_valid.
REQ-020 A transfer SHALL occur when in_valid and in_ready are both 1 at a rising edge.
REQ-021 On a transfer at edge k, the block SHALL drive we=1, write_address=PROGRAM_BASE+bytes_loaded (pre-increment value) and d=in_data during cycle k+1, and SHALL increment bytes_loaded at edge k.
REQ-022 In LOAD with no transfer, we SHALL be 0 in the following cycle.
REQ-023 A transfer with in_last=1, or a transfer whose write address is 12'hFFF, SHALL end the load and move the FSM to FLUSH at edge k.
REQ-024 At the 12'hFFF limit the load SHALL end regardless of in_last, and write_address SHALL never wrap to 12'h000.
REQ-025 FLUSH SHALL last exactly one cycle (the cycle carrying the final we pulse), then the FSM SHALL go to RUN.
REQ-026 cpu_reset SHALL be 1 in FONT, LOAD and FLUSH, and 0 in RUN; done SHALL be 1 only in RUN.
REQ-027 cpu_reset SHALL fall in the cycle immediately after the final we pulse.
REQ-028 RUN: we SHALL be 0 and in_ready 0; a reload pulse SHALL, at that edge, move the FSM to LOAD, clear bytes_loaded, set cpu_reset=1 and set done=0, without rewriting the font.
REQ-029 reload SHALL be ignored in FONT, LOAD and FLUSH.
REQ-030 The block SHALL never assert we in RUN, so it can never contend with CPU writes.

Reset
REQ-031 reset SHALL take precedence over all inputs in any state, including mid-font and mid-load.
REQ-032 While reset is high: state=FONT with the font index cleared, we=0, write_address=0, d=0, cpu_reset=1, done=0, bytes_loaded=0, in_ready=0.
REQ-033 The first font write (we=1, write_address=FONT_BASE, d=8'hF0) SHALL appear in the cycle after the first edge with reset low.
REQ-034 A partially written program SHALL NOT be resumed after reset; loading SHALL restart from PROGRAM_BASE once the font has been rewritten.

Verification
REQ-035 Reset then idle source: exactly 80 we cycles; 0x000=F0, 0x005=20, 0x04F=80; in_ready rises in the next cycle; cpu_reset stays 1.
REQ-036 Stream 00 E0 A2 2A with last on 2A and in_valid held high: writes at 0x200..0x203, one per cycle; bytes_loaded=4; cpu_reset=0 and done=1 one cycle after the 0x203 write.
REQ-037 Toggle in_valid randomly during a 16-byte load: no duplicated or dropped bytes; addresses stay contiguous 0x200..0x20F.
REQ-038 Stream 3584 bytes with in_last never asserted: the last write is at 0xFFF; the FSM enters RUN; bytes_loaded=12'hE00; no write to 0x000.
REQ-039 Assert reset after the 3rd program byte: the font is rewritten and the next load restarts at 0x200; pulse reload in RUN: cpu_reset=1, done=0, in_ready=1 next cycle, and no font writes occur.

Source files
------------

// File: rtl/chip8_rom_loader.sv
// Boot loader for a CHIP-8 system: writes the hex font into RAM, streams a program
// in from a ready/valid byte source, then releases the CPU from reset.
module chip8_rom_loader #(
  parameter logic [11:0] PROGRAM_BASE = 12'h200,
  parameter logic [11:0] FONT_BASE    = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        reload,
  output logic        we,
  output logic [11:0] write_address,
  output logic [7:0]  d,
  output logic        cpu_reset,
  output logic        done,
  output logic [11:0] bytes_loaded
);

  localparam logic [1:0] S_FONT  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam logic [6:0] FONT_LEN = 7'd80;

  // Glyphs 0..F, five rows each; byte 0 of the font sits in the top bits.
  localparam logic [639:0] FONT_ROM = {
    40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
    40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
    40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
    40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080
  };

  logic [1:0]  state_q, state_d;
  logic [6:0]  font_idx_q, font_idx_d;
  logic [11:0] bytes_q, bytes_d;
  logic        we_q, we_d;
  logic [11:0] wa_q, wa_d;
  logic [7:0]  d_q, d_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        done_q, done_d;
  logic [9:0]  font_off;
  logic [11:0] prog_addr;

  assign in_ready = (state_q == S_LOAD);

  always_comb begin
    state_d    = state_q;
    font_idx_d = font_idx_q;
    bytes_d    = bytes_q;
    we_d       = 1'b0;
    wa_d       = wa_q;
    d_d        = d_q;
    font_off   = 10'd639 - {font_idx_q, 3'b000};
    prog_addr  = PROGRAM_BASE + bytes_q;

    case (state_q)
      S_FONT: begin
        // The cycle after the last font write is spent here so in_ready rises only once the font is complete.
        if (font_idx_q == FONT_LEN) begin
          state_d = S_LOAD;
        end else begin
          we_d       = 1'b1;
          wa_d       = FONT_BASE + {5'b00000, font_idx_q};
          d_d        = FONT_ROM[font_off -: 8];
          font_idx_d = font_idx_q + 7'd1;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          we_d    = 1'b1;
          wa_d    = prog_addr;
          d_d     = in_data;
          bytes_d = bytes_q + 12'd1;
          // Top of RAM ends the load so the address never wraps into the font.
          if (in_last || prog_addr == 12'hFFF) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (reload) begin
          state_d = S_LOAD;
          bytes_d = '0;
        end
      end
      default: begin
        state_d = S_FONT;
      end
    endcase

    cpu_reset_d = (state_d != S_RUN);
    done_d      = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FONT;
      font_idx_q  <= '0;
      bytes_q     <= '0;
      we_q        <= 1'b0;
      wa_q        <= '0;
      d_q         <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      font_idx_q  <= font_idx_d;
      bytes_q     <= bytes_d;
      we_q        <= we_d;
      wa_q        <= wa_d;
      d_q         <= d_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
    end
  end

  assign we            = we_q;
  assign write_address = wa_q;
  assign d             = d_q;
  assign cpu_reset     = cpu_reset_q;
  assign done          = done_q;
  assign bytes_loaded  = bytes_q;

endmodule

// File: tb/tb_chip8_rom_loader.sv
// Self-checking bench for chip8_rom_loader: reset/font vector table, then model-driven
// program loads with randomized source behaviour.
module tb_chip8_rom_loader;

  localparam logic [11:0] PB = 12'h200;
  localparam logic [11:0] FB = 12'h000;
  localparam int M_FONT = 0, M_LOAD = 1, M_FLUSH = 2, M_RUN = 3;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_last, reload;
  logic [7:0]  in_data;
  logic        in_ready, we, cpu_reset, done;
  logic [11:0] write_address, bytes_loaded;
  logic [7:0]  d;

  chip8_rom_loader #(.PROGRAM_BASE(PB), .FONT_BASE(FB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .reload(reload), .we(we),
    .write_address(write_address), .d(d), .cpu_reset(cpu_reset),
    .done(done), .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] font_ref [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  // Reference model: load phase, bytes accepted so far, and RAM image as written.
  int          m_mode;
  int          m_count;
  logic [11:0] last_wa;
  bit          wrote_zero;
  logic [7:0]  ram [4096];

  typedef struct {
    logic        rst, v, rld;
    logic        ewe;
    logic [11:0] ewa;
    logic [7:0]  ed;
    logic        ecr, edone, erdy;
    logic [11:0] ebytes;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] dat, input bit last, input bit rld);
    bit          exp_ready, acc;
    logic [11:0] exp_wa;
    exp_ready = (m_mode == M_LOAD);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    in_valid = v; in_data = dat; in_last = last; reload = rld;
    acc    = v && exp_ready;
    exp_wa = PB + m_count[11:0];
    if (acc) begin
      m_count++;
      if (last || exp_wa == 12'hFFF) m_mode = M_FLUSH;
    end else if (m_mode == M_FLUSH) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN && rld) begin
      m_mode  = M_LOAD;
      m_count = 0;
    end
    @(negedge clk);
    chk("we", 32'(we), 32'(acc));
    if (acc) begin
      chk("write_address", 32'(write_address), 32'(exp_wa));
      chk("d", 32'(d), 32'(dat));
    end
    if (we) begin
      ram[write_address] = d;
      last_wa = write_address;
      if (write_address == 12'h000) wrote_zero = 1'b1;
    end
    chk("bytes_loaded", 32'(bytes_loaded), m_count);
    chk("cpu_reset", 32'(cpu_reset), 32'(m_mode != M_RUN));
    chk("done", 32'(done), 32'(m_mode == M_RUN));
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; reload = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(we), 0);
    chk("rst_wa", 32'(write_address), 0);
    chk("rst_d", 32'(d), 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_bytes", 32'(bytes_loaded), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    reset   = 1'b0;
    m_mode  = M_FONT;
    m_count = 0;
  endtask

  // Runs from the cycle reset is released until in_ready appears.
  task automatic font_phase(input bit noisy);
    int nwr = 0, cyc = 0, first_we = -1, last_we = -1, rdy_cyc = -1;
    bit held = 1'b1;
    while (rdy_cyc < 0 && cyc < 200) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        in_last  = 1'($urandom_range(0, 1));
        reload   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
      if (we) begin
        if (nwr < 80) begin
          chk("font_addr", 32'(write_address), 32'(FB) + nwr);
          chk("font_data", 32'(d), 32'(font_ref[nwr]));
        end
        ram[write_address] = d;
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
        nwr++;
      end
      if (in_ready) rdy_cyc = cyc;
      if (!cpu_reset || done) held = 1'b0;
    end
    chk("font_writes", nwr, 80);
    chk("font_first_cycle", first_we, 1);
    chk("ready_after_font", rdy_cyc, last_we + 1);
    chk("font_cpu_reset_held", 32'(held), 1);
    chk("font_000", 32'(ram[12'h000]), 32'h F0);
    chk("font_005", 32'(ram[12'h005]), 32'h20);
    chk("font_04F", 32'(ram[12'h04F]), 32'h80);
    in_valid = 1'b0; in_last = 1'b0; reload = 1'b0;
    m_mode = M_LOAD;
  endtask

  initial begin
    logic [7:0] prog4 [4];
    logic [7:0] pl [16];
    int sent, guard;
    bit v, take;

    //            rst v  rld  we  addr     d      cr  dn  rdy  bytes
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 12'h000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 12'h000};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 8'hF0, 1'b1, 1'b0, 1'b0, 12'h000};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h001, 8'h90, 1'b1, 1'b0, 1'b0, 12'h000};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h002, 8'h90, 1'b1, 1'b0, 1'b0, 12'h000};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h003, 8'h90, 1'b1, 1'b0, 1'b0, 12'h000};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 12'h000};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 8'hF0, 1'b1, 1'b0, 1'b0, 12'h000};

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; reload = 1'b0; in_data = '0;
    wrote_zero = 1'b0; last_wa = '0; m_mode = M_FONT; m_count = 0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      reset = vecs[i].rst; in_valid = vecs[i].v; reload = vecs[i].rld; in_data = 8'h5A;
      @(negedge clk);
      chk($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].ewe));
      chk($sformatf("vec%0d_wa", i), 32'(write_address), 32'(vecs[i].ewa));
      chk($sformatf("vec%0d_d", i), 32'(d), 32'(vecs[i].ed));
      chk($sformatf("vec%0d_cpu_reset", i), 32'(cpu_reset), 32'(vecs[i].ecr));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].edone));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].erdy));
      chk($sformatf("vec%0d_bytes", i), 32'(bytes_loaded), 32'(vecs[i].ebytes));
    end

    // Idle source after reset, then the four-byte program with valid held high.
    do_reset();
    font_phase(1'b0);
    prog4 = '{8'h00, 8'hE0, 8'hA2, 8'h2A};
    for (int i = 0; i < 4; i++) step(1'b1, prog4[i], i == 3, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("prog4_bytes", 32'(bytes_loaded), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("prog4_ram_%0h", 12'h200 + i), 32'(ram[PB + 12'(i)]), 32'(prog4[i]));

    // RUN must ignore the source entirely.
    repeat (6) step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    // Reload, then 16 bytes with a jittery valid.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
    sent = 0; guard = 0;
    while (sent < 16 && guard < 500) begin
      v    = 1'($urandom_range(0, 1));
      take = v && (m_mode == M_LOAD);
      step(v, pl[sent], sent == 15, 1'b0);
      if (take) sent++;
      guard++;
    end
    chk("load16_completed", sent, 16);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("load16_bytes", 32'(bytes_loaded), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("load16_ram_%0h", 12'h200 + i), 32'(ram[PB + 12'(i)]), 32'(pl[i]));

    // Fill to the top of RAM without in_last.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    wrote_zero = 1'b0; guard = 0;
    while (m_mode == M_LOAD && guard < 10000) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 1'b0, 1'b0);
      guard++;
    end
    chk("big_load_bounded", 32'(guard < 10000), 1);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("big_done", 32'(done), 1);
    chk("big_bytes", 32'(bytes_loaded), 32'hE00);
    chk("big_last_addr", 32'(last_wa), 32'hFFF);
    chk("big_no_wrap", 32'(wrote_zero), 0);

    // Reset mid-load: font is rewritten and the program restarts at the base.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    do_reset();
    font_phase(1'b1);
    pl[0] = 8'h12; pl[1] = 8'h34;
    for (int i = 0; i < 2; i++) step(1'b1, pl[i], i == 1, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("restart_ram_200", 32'(ram[12'h200]), 32'h12);
    chk("restart_ram_201", 32'(ram[12'h201]), 32'h34);
    chk("restart_bytes", 32'(bytes_loaded), 2);

    // Reload pulse in RUN: back to loading with no font traffic.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("reload_cpu_reset", 32'(cpu_reset), 1);
    chk("reload_done", 32'(done), 0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
